// File: rtl/cs_decoder_2_3.sv
// Erasure decoder for the systematic (2,3) cyclic-shift MDS code.
// Parity relation: p = rot(d0, SHIFT_0) ^ rot(d1, SHIFT_1); any two symbols rebuild the data.
// Two-stage valid/ready pipeline: stage 1 captures symbols and decode case, stage 2 resolves.
module cs_decoder_2_3 #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned SHIFT_0 = 1,
  parameter int unsigned SHIFT_1 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  output logic             ready_in,
  input  logic [WIDTH-1:0] coded_0,
  input  logic [WIDTH-1:0] coded_1,
  input  logic [WIDTH-1:0] coded_2,
  input  logic [2:0]       erased,
  output logic             valid_out,
  input  logic             ready_out,
  output logic [WIDTH-1:0] data_0,
  output logic [WIDTH-1:0] data_1,
  output logic             err_uncorrectable,
  output logic             parity_mismatch,
  output logic [15:0]      cnt_ok,
  output logic [15:0]      cnt_fail
);

  typedef enum logic [2:0] {
    CaseNone,
    CaseLost0,
    CaseLost1,
    CaseLostP,
    CaseFail
  } case_e;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int unsigned k);
    return (x << k) | (x >> (WIDTH - k));
  endfunction

  function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int unsigned k);
    return (x >> k) | (x << (WIDTH - k));
  endfunction

  // Stage 1 state
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_c0_q, s1_c1_q, s1_c2_q;
  case_e            s1_case_q;
  case_e            case_d;

  // Output stage state
  logic             valid_q;
  logic [WIDTH-1:0] data_0_q, data_1_q;
  logic             err_q, pm_q;
  logic [15:0]      cnt_ok_q, cnt_fail_q;

  // Stage 2 combinational result
  logic [WIDTH-1:0] res_d0, res_d1;
  logic             res_err, res_pm;

  logic out_load, in_fire, out_fire;

  assign out_load = !valid_q || ready_out;
  // Held low during reset so nothing is accepted while the pipeline is being cleared.
  assign ready_in = rst_n && (!s1_valid_q || out_load);
  assign in_fire  = valid_in && ready_in;
  assign out_fire = valid_q && ready_out;

  // Classify the erasure mask; any mask with two or more bits set is uncorrectable.
  always_comb begin
    case_d = CaseFail;
    unique case (erased)
      3'b000:  case_d = CaseNone;
      3'b001:  case_d = CaseLost0;
      3'b010:  case_d = CaseLost1;
      3'b100:  case_d = CaseLostP;
      default: case_d = CaseFail;
    endcase
  end

  // Stage 1 register: refills whenever it is empty or its word moves on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_c0_q    <= '0;
      s1_c1_q    <= '0;
      s1_c2_q    <= '0;
      s1_case_q  <= CaseNone;
    end else if (ready_in) begin
      s1_valid_q <= valid_in;
      if (in_fire) begin
        s1_c0_q   <= coded_0;
        s1_c1_q   <= coded_1;
        s1_c2_q   <= coded_2;
        s1_case_q <= case_d;
      end
    end
  end

  // Reconstruct the data by inverting the parity relation for the lost symbol.
  always_comb begin
    res_d0  = s1_c0_q;
    res_d1  = s1_c1_q;
    res_err = 1'b0;
    res_pm  = 1'b0;
    unique case (s1_case_q)
      CaseNone:  res_pm = (rotl(s1_c0_q, SHIFT_0) ^ rotl(s1_c1_q, SHIFT_1)) != s1_c2_q;
      CaseLost0: res_d0 = rotr(s1_c2_q ^ rotl(s1_c1_q, SHIFT_1), SHIFT_0);
      CaseLost1: res_d1 = rotr(s1_c2_q ^ rotl(s1_c0_q, SHIFT_0), SHIFT_1);
      CaseLostP: ;
      default: begin
        res_d0  = '0;
        res_d1  = '0;
        res_err = 1'b1;
      end
    endcase
  end

  // Output register: loads when empty or draining, holds bit-stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      data_0_q <= '0;
      data_1_q <= '0;
      err_q    <= 1'b0;
      pm_q     <= 1'b0;
    end else if (out_load) begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_0_q <= res_d0;
        data_1_q <= res_d1;
        err_q    <= res_err;
        pm_q     <= res_pm;
      end
    end
  end

  // Saturating event counters, stepped once per delivered word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ok_q   <= '0;
      cnt_fail_q <= '0;
    end else if (out_fire) begin
      if (err_q) begin
        if (cnt_fail_q != 16'hFFFF) cnt_fail_q <= cnt_fail_q + 16'd1;
      end else begin
        if (cnt_ok_q != 16'hFFFF) cnt_ok_q <= cnt_ok_q + 16'd1;
      end
    end
  end

  assign valid_out         = valid_q;
  assign data_0            = data_0_q;
  assign data_1            = data_1_q;
  assign err_uncorrectable = err_q;
  assign parity_mismatch   = pm_q;
  assign cnt_ok            = cnt_ok_q;
  assign cnt_fail          = cnt_fail_q;

endmodule

// File: tb/tb_cs_decoder_2_3.sv
// Directed self-checking bench for cs_decoder_2_3 (WIDTH=4, SHIFT_0=1, SHIFT_1=2).
module tb_cs_decoder_2_3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_in;
  logic       ready_in;
  logic [3:0] coded_0, coded_1, coded_2;
  logic [2:0] erased;
  logic       valid_out;
  logic       ready_out;
  logic [3:0] data_0, data_1;
  logic       err_uncorrectable, parity_mismatch;
  logic [15:0] cnt_ok, cnt_fail;

  int n_cmp = 0;
  int n_bad = 0;

  cs_decoder_2_3 #(.WIDTH(4), .SHIFT_0(1), .SHIFT_1(2)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .valid_in          (valid_in),
    .ready_in          (ready_in),
    .coded_0           (coded_0),
    .coded_1           (coded_1),
    .coded_2           (coded_2),
    .erased            (erased),
    .valid_out         (valid_out),
    .ready_out         (ready_out),
    .data_0            (data_0),
    .data_1            (data_1),
    .err_uncorrectable (err_uncorrectable),
    .parity_mismatch   (parity_mismatch),
    .cnt_ok            (cnt_ok),
    .cnt_fail          (cnt_fail)
  );

  always #5 clk = ~clk;

  // Drive one word into an empty pipeline and capture the decoded result.
  task automatic run_word(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                          input logic [2:0] er, output logic [3:0] d0, output logic [3:0] d1,
                          output logic err, output logic pm, output int lat);
    @(posedge clk); #1;
    ready_out = 1'b1;
    valid_in  = 1'b1;
    coded_0   = c0;
    coded_1   = c1;
    coded_2   = c2;
    erased    = er;
    @(posedge clk); #1;
    valid_in = 1'b0;
    coded_0  = 4'h5;
    coded_1  = 4'h5;
    coded_2  = 4'h5;
    erased   = 3'b111;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!valid_out && lat < 10);
    d0  = data_0;
    d1  = data_1;
    err = err_uncorrectable;
    pm  = parity_mismatch;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
    coded_0 = '0; coded_1 = '0; coded_2 = '0; erased = '0;
    #12;
    n_cmp++;
    if (ready_in !== 1'b0 || valid_out !== 1'b0) begin
      n_bad++; $display("FAIL reset_hs: ready_in=%b valid_out=%b want 0/0", ready_in, valid_out);
    end
    n_cmp++;
    if (data_0 !== 4'h0 || data_1 !== 4'h0 || err_uncorrectable !== 1'b0
        || parity_mismatch !== 1'b0) begin
      n_bad++; $display("FAIL reset_data: d0=%h d1=%h err=%b pm=%b want 0", data_0, data_1,
                        err_uncorrectable, parity_mismatch);
    end
    n_cmp++;
    if (cnt_ok !== 16'h0 || cnt_fail !== 16'h0) begin
      n_bad++; $display("FAIL reset_cnt: ok=%h fail=%h want 0/0", cnt_ok, cnt_fail);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (ready_in !== 1'b1) begin
      n_bad++; $display("FAIL reset_release_ready: ready_in=%b want 1", ready_in);
    end
  endtask

  task automatic test_clean();
    logic [3:0] d0, d1; logic err, pm; int lat;
    run_word(4'b1001, 4'b0110, 4'b1010, 3'b000, d0, d1, err, pm, lat);
    n_cmp++;
    if (lat !== 1) begin
      n_bad++; $display("FAIL clean_latency: cycles=%0d want 1", lat);
    end
    n_cmp++;
    if (d0 !== 4'b1001 || d1 !== 4'b0110 || pm !== 1'b0 || err !== 1'b0) begin
      n_bad++; $display("FAIL clean_word: d0=%b d1=%b pm=%b err=%b want 1001/0110/0/0",
                        d0, d1, pm, err);
    end
    n_cmp++;
    if (cnt_ok !== 16'd1) begin
      n_bad++; $display("FAIL clean_cnt_ok: got %0d want 1", cnt_ok);
    end
  endtask

  task automatic test_erasure();
    logic [3:0] d0, d1; logic err, pm; int lat;
    run_word(4'hF, 4'b0110, 4'b1010, 3'b001, d0, d1, err, pm, lat);
    n_cmp++;
    if (d0 !== 4'b1001 || d1 !== 4'b0110 || err !== 1'b0 || pm !== 1'b0) begin
      n_bad++; $display("FAIL lost0: d0=%b d1=%b err=%b pm=%b want 1001/0110/0/0",
                        d0, d1, err, pm);
    end
    run_word(4'b1001, 4'hF, 4'b1010, 3'b010, d0, d1, err, pm, lat);
    n_cmp++;
    if (d0 !== 4'b1001 || d1 !== 4'b0110 || err !== 1'b0 || pm !== 1'b0) begin
      n_bad++; $display("FAIL lost1: d0=%b d1=%b err=%b pm=%b want 1001/0110/0/0",
                        d0, d1, err, pm);
    end
    run_word(4'b1001, 4'b0110, 4'hF, 3'b100, d0, d1, err, pm, lat);
    n_cmp++;
    if (d0 !== 4'b1001 || d1 !== 4'b0110 || err !== 1'b0 || pm !== 1'b0) begin
      n_bad++; $display("FAIL lostp: d0=%b d1=%b err=%b pm=%b want 1001/0110/0/0",
                        d0, d1, err, pm);
    end
    n_cmp++;
    if (cnt_ok !== 16'd4) begin
      n_bad++; $display("FAIL erasure_cnt_ok: got %0d want 4", cnt_ok);
    end
  endtask

  task automatic test_parity();
    logic [3:0] d0, d1; logic err, pm; int lat;
    run_word(4'hA, 4'h3, 4'h0, 3'b000, d0, d1, err, pm, lat);
    n_cmp++;
    if (pm !== 1'b1 || d0 !== 4'hA || d1 !== 4'h3 || err !== 1'b0) begin
      n_bad++; $display("FAIL parity_bad: pm=%b d0=%h d1=%h err=%b want 1/A/3/0",
                        pm, d0, d1, err);
    end
    run_word(4'hA, 4'h3, 4'h9, 3'b000, d0, d1, err, pm, lat);
    n_cmp++;
    if (pm !== 1'b0) begin
      n_bad++; $display("FAIL parity_good: pm=%b want 0", pm);
    end
  endtask

  task automatic test_fail();
    logic [2:0] masks [4] = '{3'b011, 3'b101, 3'b110, 3'b111};
    logic [3:0] d0, d1; logic err, pm; int lat;
    for (int i = 0; i < 4; i++) begin
      run_word(4'h9, 4'h6, 4'hA, masks[i], d0, d1, err, pm, lat);
      n_cmp++;
      if (d0 !== 4'h0 || d1 !== 4'h0 || err !== 1'b1 || pm !== 1'b0) begin
        n_bad++; $display("FAIL uncorrectable_%b: d0=%h d1=%h err=%b pm=%b want 0/0/1/0",
                          masks[i], d0, d1, err, pm);
      end
      n_cmp++;
      if (cnt_fail !== 16'(i + 1)) begin
        n_bad++; $display("FAIL cnt_fail_%0d: got %0d want %0d", i, cnt_fail, i + 1);
      end
    end
    n_cmp++;
    if (cnt_ok !== 16'd6) begin
      n_bad++; $display("FAIL fail_cnt_ok_hold: got %0d want 6", cnt_ok);
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    int cyc = 0;
    bit saw_low = 0;
    bit have_prev = 0;
    logic [3:0] prev_d0, prev_d1, exp0, exp1;
    fork
      begin : producer
        for (int i = 0; i < 8; i++) begin
          int tries = 0;
          @(posedge clk); #1;
          valid_in = 1'b1;
          coded_0  = 4'(i);
          coded_1  = ~4'(i);
          coded_2  = 4'h0;
          erased   = 3'b100;
          #1;
          while (!ready_in && tries < 200) begin
            @(posedge clk); #2;
            tries++;
          end
        end
        @(posedge clk); #1;
        valid_in = 1'b0;
      end
      begin : consumer
        while (got < 8 && cyc < 200) begin
          @(posedge clk); #1;
          ready_out = (cyc % 4 == 0) || (cyc % 4 == 3);
          #1;
          if (!ready_in) saw_low = 1;
          if (have_prev) begin
            n_cmp++;
            if (valid_out !== 1'b1 || data_0 !== prev_d0 || data_1 !== prev_d1) begin
              n_bad++; $display("FAIL stall_stable: v=%b d0=%h d1=%h want 1/%h/%h",
                                valid_out, data_0, data_1, prev_d0, prev_d1);
            end
            have_prev = 0;
          end
          if (valid_out) begin
            if (ready_out) begin
              exp0 = 4'(got);
              exp1 = ~exp0;
              n_cmp++;
              if (data_0 !== exp0 || data_1 !== exp1) begin
                n_bad++; $display("FAIL bp_word_%0d: d0=%h d1=%h want %h/%h",
                                  got, data_0, data_1, exp0, exp1);
              end
              got++;
            end else begin
              have_prev = 1;
              prev_d0 = data_0;
              prev_d1 = data_1;
            end
          end
          cyc++;
        end
      end
    join
    @(posedge clk); #1;
    ready_out = 1'b1;
    n_cmp++;
    if (got !== 8) begin
      n_bad++; $display("FAIL bp_count: got %0d words want 8", got);
    end
    n_cmp++;
    if (saw_low !== 1'b1) begin
      n_bad++; $display("FAIL bp_ready_drop: saw_low=%b want 1", saw_low);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (cnt_ok !== 16'd14) begin
      n_bad++; $display("FAIL bp_cnt_ok: got %0d want 14", cnt_ok);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w;
    ready_out = 1'b1;
    for (int j = 0; j < 10; j++) begin
      @(posedge clk); #1;
      if (j >= 2) begin
        w = 4'(j - 2);
        n_cmp++;
        if (valid_out !== 1'b1 || data_0 !== w || data_1 !== (w ^ 4'h5)) begin
          n_bad++; $display("FAIL b2b_word_%0d: v=%b d0=%h d1=%h want 1/%h/%h", j - 2,
                            valid_out, data_0, data_1, w, w ^ 4'h5);
        end
      end
      if (j < 8) begin
        valid_in = 1'b1;
        coded_0  = 4'(j);
        coded_1  = 4'(j) ^ 4'h5;
        coded_2  = 4'h0;
        erased   = 3'b100;
        n_cmp++;
        if (ready_in !== 1'b1) begin
          n_bad++; $display("FAIL b2b_ready_%0d: ready_in=%b want 1", j, ready_in);
        end
      end else begin
        valid_in = 1'b0;
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (valid_out !== 1'b0 || cnt_ok !== 16'd22) begin
      n_bad++; $display("FAIL b2b_end: v=%b cnt_ok=%0d want 0/22", valid_out, cnt_ok);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] d0, d1; logic err, pm; int lat;
    logic [15:0] exp [3] = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    @(posedge clk); #1;
    force dut.cnt_ok_q = 16'hFFFD;
    #1;
    release dut.cnt_ok_q;
    for (int i = 0; i < 3; i++) begin
      run_word(4'h9, 4'h6, 4'hA, 3'b000, d0, d1, err, pm, lat);
      n_cmp++;
      if (cnt_ok !== exp[i]) begin
        n_bad++; $display("FAIL sat_%0d: cnt_ok=%h want %h", i, cnt_ok, exp[i]);
      end
    end
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    ready_out = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      coded_0  = 4'h7;
      coded_1  = 4'h7;
      coded_2  = 4'h0;
      erased   = 3'b100;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (valid_out !== 1'b0 || data_0 !== 4'h0 || data_1 !== 4'h0 || ready_in !== 1'b0) begin
      n_bad++; $display("FAIL midreset_out: v=%b d0=%h d1=%h rdy=%b want 0/0/0/0",
                        valid_out, data_0, data_1, ready_in);
    end
    n_cmp++;
    if (cnt_ok !== 16'h0 || cnt_fail !== 16'h0) begin
      n_bad++; $display("FAIL midreset_cnt: ok=%h fail=%h want 0/0", cnt_ok, cnt_fail);
    end
    @(posedge clk); #1;
    ready_out = 1'b1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (valid_out) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin
      n_bad++; $display("FAIL midreset_stale: valid_out cycles=%0d want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_erasure();
    test_parity();
    test_fail();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
